// File: rtl/sha256_tx_pkg.sv
// sha256_tx_pkg: shared FSM state type and digest geometry for sha256_digest_tx
package sha256_tx_pkg;
  localparam int SHA_WORDS  = 8;
  localparam int SHA_WORD_W = 32;
  localparam int SHA_DIG_W  = 256;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/sha256_digest_tx_if.sv
// sha256_digest_tx_if: digest-in / word-out handshake bundle; master = the block, slave = its environment
interface sha256_digest_tx_if;
  import sha256_tx_pkg::*;
  logic                  dig_load_i;
  logic [SHA_DIG_W-1:0]  dig_data_i;
  logic                  dig_ready_o;
  logic                  word_valid_o;
  logic                  word_ready_i;
  logic [SHA_WORD_W-1:0] word_data_o;
  logic [2:0]            word_idx_o;
  logic                  word_last_o;
  logic                  busy_o;
  logic                  overrun_o;
  modport master (
    input  dig_load_i, dig_data_i, word_ready_i,
    output dig_ready_o, word_valid_o, word_data_o, word_idx_o, word_last_o, busy_o, overrun_o
  );
  modport slave (
    output dig_load_i, dig_data_i, word_ready_i,
    input  dig_ready_o, word_valid_o, word_data_o, word_idx_o, word_last_o, busy_o, overrun_o
  );
endinterface

// File: rtl/sha256_word_sel.sv
// sha256_word_sel: combinational 8:1 selection of one 32-bit word from a 256-bit digest
module sha256_word_sel
  import sha256_tx_pkg::*;
#(
  parameter bit MSW_FIRST = 1
) (
  input  logic [SHA_DIG_W-1:0]  digest,
  input  logic [2:0]            idx,
  output logic [SHA_WORD_W-1:0] word
);
  logic [2:0] sel;
  always_comb begin
    sel  = MSW_FIRST ? ~idx : idx;
    word = digest[{sel, 5'd0} +: SHA_WORD_W];
  end
endmodule

// File: rtl/sha256_digest_tx.sv
// sha256_digest_tx: serialises a 256-bit SHA-256 digest into eight 32-bit words over valid/ready.
// Optional SHA_TX_DBUF_EN adds a pending digest register for gap-free back-to-back transfers.
module sha256_digest_tx
  import sha256_tx_pkg::*;
#(
  parameter bit MSW_FIRST = 1
) (
  input logic                clk,
  input logic                rst,
  sha256_digest_tx_if.master bus
);
  state_t               state, state_nx;
  logic [SHA_DIG_W-1:0] act, act_nx, pend;
  logic [2:0]           idx;
  logic                 pend_v, ovr, acc, hs, fin;
`ifdef SHA_TX_DBUF_EN
  assign bus.dig_ready_o = !rst && !pend_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_v <= 1'b0;
      pend   <= '0;
    end else if (acc && state == SEND && !fin) begin
      pend_v <= 1'b1;
      pend   <= bus.dig_data_i;
    end else if (fin) begin
      pend_v <= 1'b0;
    end
`else
  assign pend_v          = 1'b0;
  assign pend            = '0;
  assign bus.dig_ready_o = !rst && state == IDLE;
`endif
  assign acc = bus.dig_load_i && bus.dig_ready_o;
  assign hs  = bus.word_valid_o && bus.word_ready_i;
  assign fin = hs && idx == 3'd7;
  always_comb begin
    state_nx = (state == IDLE) ? (acc ? SEND : IDLE) : ((fin && !pend_v && !acc) ? IDLE : SEND);
    act_nx   = (acc && (state == IDLE || fin)) ? bus.dig_data_i : (fin && pend_v) ? pend : act;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      act   <= '0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nx;
      act   <= act_nx;
      ovr   <= bus.dig_load_i && !bus.dig_ready_o;
      idx   <= (acc && state == IDLE) ? 3'd0 : hs ? idx + 3'd1 : idx;
    end
  sha256_word_sel #(.MSW_FIRST(MSW_FIRST)) u_sel (
    .digest(act),
    .idx   (idx),
    .word  (bus.word_data_o)
  );
  assign bus.word_valid_o = state == SEND;
  assign bus.word_idx_o   = idx;
  assign bus.word_last_o  = bus.word_valid_o && idx == 3'd7;
  assign bus.busy_o       = state == SEND || pend_v;
  assign bus.overrun_o    = ovr;
endmodule

// File: tb/tb_sha256_digest_tx.sv
// tb_sha256_digest_tx: scoreboard bench; MSW_FIRST=1 and MSW_FIRST=0 instances run on identical stimulus
module tb_sha256_digest_tx;
  import sha256_tx_pkg::*;
  typedef struct {
    logic [31:0] w1;
    logic [31:0] w0;
    logic [2:0]  idx;
  } item_t;
`ifdef SHA_TX_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic         clk = 1'b0, rst = 1'b1, load = 1'b0, ready = 1'b0, exp_ovr = 1'b0, v;
  logic [255:0] data = '0;
  item_t        q[$];
  item_t        it;
  int           n_chk = 0, n_fail = 0;
  sha256_digest_tx_if b1 ();
  sha256_digest_tx_if b0 ();
  assign b1.dig_load_i   = load;
  assign b1.dig_data_i   = data;
  assign b1.word_ready_i = ready;
  assign b0.dig_load_i   = load;
  assign b0.dig_data_i   = data;
  assign b0.word_ready_i = ready;
  sha256_digest_tx #(.MSW_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  sha256_digest_tx #(.MSW_FIRST(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  always #5 clk = ~clk;
  // pending slot is free while at most one digest's worth of words is outstanding
  function automatic logic model_ready();
    return DBUF ? (q.size() <= 8) : (q.size() == 0);
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(logic [255:0] d);
    for (int k = 0; k < 8; k++) q.push_back('{d[255-32*k -: 32], d[32*k +: 32], 3'(k)});
  endtask
  task automatic cyc(logic l, logic [255:0] d, logic r);
    logic acc, ovr;
    load = l;
    data = d;
    ready = r;
    acc = l && model_ready();
    ovr = l && !model_ready();
    @(posedge clk);
    if (acc) push(d);
    exp_ovr = ovr;
    #1;
  endtask
  task automatic do_reset();
    load = 1'b0;
    rst = 1'b1;
    q.delete();
    exp_ovr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  always @(negedge clk) begin
    v = q.size() > 0;
    if (rst) begin
      chk("rst_valid", b1.word_valid_o, 0);
      chk("rst_ready", b1.dig_ready_o, 0);
      chk("rst_data", b1.word_data_o, 0);
      chk("rst_idx", b1.word_idx_o, 0);
      chk("rst_last", b1.word_last_o, 0);
      chk("rst_busy", b1.busy_o, 0);
      chk("rst_ovr", b1.overrun_o, 0);
      chk("rst_valid0", b0.word_valid_o, 0);
    end else begin
      chk("valid", b1.word_valid_o, v);
      chk("valid_lsw", b0.word_valid_o, v);
      chk("dig_ready", b1.dig_ready_o, model_ready());
      chk("busy", b1.busy_o, v);
      chk("overrun", b1.overrun_o, exp_ovr);
      if (v) begin
        it = q[0];
        chk("data", b1.word_data_o, it.w1);
        chk("idx", b1.word_idx_o, it.idx);
        chk("last", b1.word_last_o, it.idx == 3'd7);
        chk("data_lsw", b0.word_data_o, it.w0);
        chk("idx_lsw", b0.word_idx_o, it.idx);
        if (ready) q.pop_front();
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, ABC, 1'b1);
    repeat (10) cyc(1'b0, rnd256(), 1'b1);
    cyc(1'b1, ABC, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, rnd256(), i % 2 == 0);
    cyc(1'b1, rnd256(), 1'b1);
    repeat (3) cyc(1'b0, rnd256(), 1'b1);
    cyc(1'b1, rnd256(), 1'b1);
    repeat (20) cyc(1'b0, rnd256(), 1'b1);
    cyc(1'b1, ABC, 1'b1);
    repeat (5) cyc(1'b0, rnd256(), 1'b1);
    do_reset();
    cyc(1'b1, ABC, 1'b1);
    repeat (10) cyc(1'b0, rnd256(), 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 5) == 0, rnd256(), $urandom_range(0, 2) != 0);
    end
    repeat (40) cyc(1'b0, rnd256(), 1'b1);
    chk("drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
